// File: rtl/riscy_uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
// The optional UART_RX_PARITY_EN build adds the StParity state to the receiver.
package riscy_uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: the head entry sits on rdata_o while the FIFO is non-empty.
// A pop and a push in the same cycle are both accepted when the FIFO is full.
module uart_rx_fifo
    import riscy_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [UART_DATA_W-1:0] wdata_i,
    input  logic                   pop_i,
    output logic [UART_DATA_W-1:0] rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] FullLvl = DEPTH[AW:0];

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            level_q;
    logic [AW:0]            level_d;
    logic                   push_ok;
    logic                   pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FullLvl);
    assign level_o = level_q;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver feeding a show-ahead FIFO, with sticky framing and overrun flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity checked before the stop bit).
module uart_receiver
    import riscy_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        uart_rx,
    input  logic                        rd_en,
    output logic [UART_DATA_W-1:0]      rd_data,
    output logic                        rx_valid,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        clr_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]             sync_q;
    logic                   rx_s;
    uart_rx_state_e         state_q;
    logic [CntW-1:0]        cnt_q;
    logic [2:0]             bit_idx_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   cnt_done;
    logic                   stop_sample;
    logic                   frame_ok;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx};
        end
    end

    assign rx_s        = sync_q[1];
    assign cnt_done    = (cnt_q == '0);
    assign stop_sample = (state_q == StStop) && cnt_done;

`ifdef UART_RX_PARITY_EN
    logic par_err_q;
    assign frame_ok = rx_s && !par_err_q;
`else
    assign frame_ok = rx_s;
`endif

    // The byte enters the FIFO on the stop-sample edge itself.
    assign push = stop_sample && frame_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= HalfLoad;
                    end
                end
                StStart: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else if (rx_s) begin
                        state_q <= StIdle;
                    end else begin
                        state_q   <= StData;
                        cnt_q     <= BitLoad;
                        bit_idx_q <= '0;
                    end
                end
                StData: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        shift_q   <= {rx_s, shift_q[UART_DATA_W-1:1]};
                        cnt_q     <= BitLoad;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        par_err_q <= (rx_s != ^shift_q);
                        cnt_q     <= BitLoad;
                        state_q   <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Clear first so a same-cycle error event wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (clr_err) begin
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
            if (stop_sample && !frame_ok) frame_err_q <= 1'b1;
            if (push && fifo_full && !rd_en) overrun_q <= 1'b1;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_valid  = !fifo_empty;

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (resetn),
        .push_i (push),
        .wdata_i(shift_q),
        .pop_i  (rd_en),
        .rdata_o(rd_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .level_o(rx_level)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed and random frames against a byte-queue model.
// Build with UART_RX_PARITY_EN defined to exercise 8E1 frames.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int unsigned Cpb   = 16;
    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] rx_level;
    logic       frame_err;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_q[$];
    bit         model_fe;
    bit         model_ov;

    uart_receiver #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (Depth)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .uart_rx  (uart_rx),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rx_valid (rx_valid),
        .rx_level (rx_level),
        .frame_err(frame_err),
        .overrun  (overrun),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] head();
        return (model_q.size() > 0) ? model_q[0] : 8'h00;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, " level"}, 32'(rx_level), 32'(model_q.size()));
        check_eq({tag, " valid"}, 32'(rx_valid), 32'(model_q.size() != 0));
        check_eq({tag, " data"}, 32'(rd_data), 32'(head()));
        check_eq({tag, " frame_err"}, 32'(frame_err), 32'(model_fe));
        check_eq({tag, " overrun"}, 32'(overrun), 32'(model_ov));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " data"}, 32'(rd_data), 32'h0);
        check_eq({tag, " valid"}, 32'(rx_valid), 32'h0);
        check_eq({tag, " level"}, 32'(rx_level), 32'h0);
        check_eq({tag, " frame_err"}, 32'(frame_err), 32'h0);
        check_eq({tag, " overrun"}, 32'(overrun), 32'h0);
    endtask

    // Drives one frame. Bit b is sampled on the 11th edge after it is driven
    // (2-cycle synchronizer, detect edge, then half a bit), so the stop-sample edge is i == 11.
    task automatic send_frame(input logic [7:0] data, input bit stop, input bit bad_par,
                              input bit pop_at_stop, input string tag);
        logic bits[11];
        int   nb;
        bit   ok;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = data[k];
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^data) ^ bad_par;
        bits[10] = stop;
        nb = 11;
`else
        bits[9] = stop;
        nb = 10;
`endif
        for (int b = 0; b < nb; b++) begin
            uart_rx = bits[b];
            for (int i = 1; i <= int'(Cpb); i++) begin
                tick();
                if (b == nb - 1 && i == 10) begin
                    check_eq({tag, " pre-stop level"}, 32'(rx_level), 32'(model_q.size()));
                    if (pop_at_stop) begin
                        check_eq({tag, " pre-stop data"}, 32'(rd_data), 32'(head()));
                        rd_en = 1'b1;
                    end
                end
                if (b == nb - 1 && i == 11) begin
                    rd_en = 1'b0;
                    ok = stop && !bad_par;
                    if (pop_at_stop && model_q.size() > 0) void'(model_q.pop_front());
                    if (!ok) model_fe = 1'b1;
                    else if (model_q.size() < int'(Depth)) model_q.push_back(data);
                    else model_ov = 1'b1;
                    check_eq({tag, " post-stop level"}, 32'(rx_level), 32'(model_q.size()));
                end
            end
        end
        uart_rx = 1'b1;
        repeat (20) tick();
    endtask

    task automatic pop_check(input string tag);
        check_eq({tag, " pop data"}, 32'(rd_data), 32'(head()));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        check_eq({tag, " pop level"}, 32'(rx_level), 32'(model_q.size()));
    endtask

    task automatic clear_flags(input string tag);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        model_fe = 1'b0;
        model_ov = 1'b0;
        check_eq({tag, " clr frame_err"}, 32'(frame_err), 32'h0);
        check_eq({tag, " clr overrun"}, 32'(overrun), 32'h0);
    endtask

    initial begin
        logic [7:0] d;
        bit         stp;
        bit         bp;
        bit         pas;

        resetn  = 1'b0;
        uart_rx = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        model_fe = 1'b0;
        model_ov = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        resetn = 1'b1;
        repeat (3) tick();
        check_state("after reset");

        send_frame(8'h55, 1'b1, 1'b0, 1'b0, "b55");
        check_state("b55");
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0, "bA3");
        check_state("bA3");
        pop_check("rd1");
        pop_check("rd2");
        pop_check("rd empty");
        check_state("two bytes drained");

        uart_rx = 1'b0;
        repeat (4) tick();
        uart_rx = 1'b1;
        repeat (40) tick();
        check_state("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, "stop low");
        check_state("stop low");
        clear_flags("ferr");

        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0, 1'b0, "fill");
        check_state("overrun");
        for (int k = 0; k < 4; k++) pop_check("ovr drain");
        check_state("ovr drained");
        clear_flags("ovr");

        for (int k = 0; k < 4; k++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, "prefill");
        send_frame(8'h77, 1'b1, 1'b0, 1'b1, "b77 pop");
        check_state("b77 pop");
        for (int k = 0; k < 3; k++) pop_check("b77 drain");
        check_eq("b77 last out", 32'(rd_data), 32'h77);
        pop_check("b77 final");

        send_frame(8'hC4, 1'b1, 1'b0, 1'b0, "pre-reset");
        uart_rx = 1'b0;
        repeat (40) begin
            tick();
            uart_rx = 1'($urandom);
        end
        resetn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            uart_rx = 1'($urandom);
            tick();
            check_reset_vals("in reset");
        end
        uart_rx = 1'b1;
        model_q.delete();
        model_fe = 1'b0;
        model_ov = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (5) tick();
        send_frame(8'h9E, 1'b1, 1'b0, 1'b0, "b9E");
        check_state("b9E");
        pop_check("b9E");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, "bad parity");
        check_state("bad parity");
        clear_flags("par");
`endif

        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom);
            stp = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            bp  = ($urandom_range(0, 5) == 0);
`else
            bp  = 1'b0;
`endif
            pas = ($urandom_range(0, 3) == 0);
            send_frame(d, stp, bp, pas, "rand");
            check_state("rand");
            repeat ($urandom_range(0, 2)) pop_check("rand");
            if ($urandom_range(0, 4) == 0) clear_flags("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
